// File: rtl/sbox_layer_pipe.sv
// sbox_layer_pipe: N-lane table substitution with one registered valid/ready stage and a runtime-writable table
module sbox_layer_pipe #(
   parameter int LANES = 8,
   parameter int IN_W  = 6,
   parameter int OUT_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   input  logic                   tbl_we,
   input  logic [IN_W-1:0]        tbl_addr,
   input  logic [OUT_W-1:0]       tbl_wdata,
   output logic                   tbl_wr_err,
   output logic [CNT_W-1:0]       blk_cnt
);
   localparam int DEPTH = 1 << IN_W;
   // 6-to-4 sbox packed with entry a at bits [a*4 +: 4]
   localparam logic [255:0] SBOX = 256'h3E5043C6950CF96FD827ED1C7BC182B4698E903DCFF3055816DB7A47C124BCE2;

   function automatic logic [OUT_W-1:0] def_entry(input int a);
      if (IN_W == 6 && OUT_W == 4) return OUT_W'(SBOX[(a & 63)*4 +: 4]);
      return OUT_W'(a);
   endfunction

   logic [OUT_W-1:0]       r_tbl [DEPTH];
   logic                   r_valid;
   logic [LANES*OUT_W-1:0] r_data;
   logic                   r_wr_err;
   logic [CNT_W-1:0]       r_cnt;
   logic [LANES*OUT_W-1:0] w_lut;
   logic                   w_acc;
   logic                   w_idle;

   assign in_ready   = !r_valid || out_ready;
   assign w_acc      = in_valid && in_ready;
   assign w_idle     = !r_valid && !in_valid;
   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign tbl_wr_err = r_wr_err;
   assign blk_cnt    = r_cnt;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_lut[k*OUT_W +: OUT_W] = r_tbl[in_data[k*IN_W +: IN_W]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= def_entry(i);
      end else if (tbl_we && w_idle) begin
         r_tbl[tbl_addr] <= tbl_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_wr_err <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_wr_err <= tbl_we && !w_idle;
         if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_lut;
            r_cnt   <= r_cnt + 1'b1;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sbox_layer_pipe.sv
// tb_sbox_layer_pipe: directed and scoreboard-checked bench for sbox_layer_pipe
module tb_sbox_layer_pipe;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [47:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1;
   logic [31:0] out_data;
   logic        tbl_we = 0;
   logic [5:0]  tbl_addr = '0;
   logic [3:0]  tbl_wdata = '0;
   logic        tbl_wr_err;
   logic [15:0] blk_cnt;

   logic        c_in_ready, c_out_valid, c_wr_err;
   logic [31:0] c_out_data;
   logic [3:0]  c_cnt;

   logic        s_valid = 0;
   logic        s_in_ready, s_out_valid, s_wr_err;
   logic [2:0]  s_data = '0;
   logic [1:0]  s_out;
   logic [15:0] s_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int pops = 0;
   int stalls = 0;
   logic [31:0] exp_q[$];

   localparam logic [3:0] DEF [64] = '{
      4'h2,4'hE,4'hC,4'hB,4'h4,4'h2,4'h1,4'hC,4'h7,4'h4,4'hA,4'h7,4'hB,4'hD,4'h6,4'h1,
      4'h8,4'h5,4'h5,4'h0,4'h3,4'hF,4'hF,4'hC,4'hD,4'h3,4'h0,4'h9,4'hE,4'h8,4'h9,4'h6,
      4'h4,4'hB,4'h2,4'h8,4'h1,4'hC,4'hB,4'h7,4'hC,4'h1,4'hD,4'hE,4'h7,4'h2,4'h8,4'hD,
      4'hF,4'h6,4'h9,4'hF,4'hC,4'h0,4'h5,4'h9,4'h6,4'hC,4'h3,4'h4,4'h0,4'h5,4'hE,4'h3};
   logic [3:0] m_tbl [64] = DEF;

   sbox_layer_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .tbl_we(tbl_we),
      .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_wr_err(tbl_wr_err), .blk_cnt(blk_cnt));

   sbox_layer_pipe #(.CNT_W(4)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .tbl_we(tbl_we),
      .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_wr_err(c_wr_err), .blk_cnt(c_cnt));

   sbox_layer_pipe #(.LANES(1), .IN_W(3), .OUT_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_in_ready), .in_data(s_data),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out), .tbl_we(1'b0),
      .tbl_addr(3'd0), .tbl_wdata(2'd0), .tbl_wr_err(s_wr_err), .blk_cnt(s_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s act=%0h req=%0h", n, a, e);
      end
   endtask

   function automatic logic [31:0] exp_of(input logic [47:0] d);
      logic [31:0] r;
      for (int k = 0; k < 8; k++) r[k*4 +: 4] = m_tbl[d[k*6 +: 6]];
      return r;
   endfunction

   function automatic logic [47:0] rnd();
      logic [47:0] d;
      d[31:0]  = $urandom();
      d[47:32] = 16'($urandom());
      return d;
   endfunction

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [47:0] d, input logic [31:0] e);
      in_valid = 1;
      in_data  = d;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            return;
         end
         stalls++;
         @(posedge clk); #1;
      end
      chk("send_timeout", 0, 1);
   endtask

   task automatic wr(input logic [5:0] a, input logic [3:0] d);
      tbl_we = 1;
      tbl_addr = a;
      tbl_wdata = d;
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         pops++;
         if (exp_q.size() == 0) chk("unexpected_out", {32'h0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         else chk("out_data", {32'h0, out_data}, {32'h0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1);
   end

   initial begin
      logic [47:0] d;
      logic [31:0] ea;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_wr_err", tbl_wr_err, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      send({6'h1C,6'h2A,6'h35,6'h13,6'h20,6'h3F,6'h01,6'h00}, 32'hED00_43E2);
      in_valid = 0;
      @(negedge clk);
      chk("first_valid", out_valid, 1);
      chk("first_cnt", blk_cnt, 1);
      @(posedge clk); #1;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         d = rnd();
         send(d, exp_of(d));
      end
      in_valid = 0;
      in_data = 'x;
      @(negedge clk);
      chk("stream_stalls", stalls, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream_cnt", blk_cnt, 101);
      chk("stream_pops", pops, 101);
      chk("x_idle_valid", out_valid, 0);
      chk("x_idle_known", $isunknown(out_data), 0);
      @(posedge clk); #1;
      out_ready = 0;
      d = rnd();
      ea = exp_of(d);
      send(d, ea);
      d = rnd();
      in_data = d;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, ea);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data2", out_data, ea);
      @(posedge clk); #1;
      out_ready = 1;
      send(d, exp_of(d));
      in_valid = 0;
      @(negedge clk);
      chk("bp_second_valid", out_valid, 1);
      chk("bp_cnt", blk_cnt, 103);
      @(posedge clk); #1;
      wr(6'h00, 4'h9);
      tbl_we = 0;
      m_tbl[0] = 4'h9;
      @(negedge clk);
      chk("wr_ok_err", tbl_wr_err, 0);
      @(posedge clk); #1;
      send({8{6'h00}}, 32'h9999_9999);
      in_valid = 0;
      @(posedge clk); #1;
      wr(6'h02, 4'hA);
      wr(6'h03, 4'h5);
      tbl_we = 0;
      m_tbl[2] = 4'hA;
      m_tbl[3] = 4'h5;
      send({4{6'h03,6'h02}}, 32'h5A5A_5A5A);
      in_valid = 0;
      @(posedge clk); #1;
      out_ready = 0;
      send({8{6'h01}}, 32'hEEEE_EEEE);
      in_valid = 0;
      wr(6'h01, 4'h5);
      tbl_we = 0;
      @(negedge clk);
      chk("wr_busy_err", tbl_wr_err, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_err_pulse", tbl_wr_err, 0);
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      send({8{6'h01}}, 32'hEEEE_EEEE);
      in_valid = 0;
      @(posedge clk); #1;
      out_ready = 0;
      send({8{6'h00}}, 32'h9999_9999);
      in_valid = 0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_cnt", blk_cnt, 0);
      exp_q.delete();
      m_tbl = DEF;
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      out_ready = 1;
      send({8{6'h00}}, 32'h2222_2222);
      in_valid = 0;
      @(negedge clk);
      chk("post_rst_cnt", blk_cnt, 1);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         d = rnd();
         send(d, exp_of(d));
      end
      in_valid = 0;
      @(negedge clk);
      chk("cnt16_main", blk_cnt, 17);
      chk("cnt4_wrap", c_cnt, 1);
      @(posedge clk); #1;
      foreach (ea[i]) if (i < 3) begin
         s_valid = 1;
         s_data = (i == 0) ? 3'd5 : (i == 1) ? 3'd6 : 3'd3;
         @(posedge clk); #1;
         @(negedge clk);
         chk("small_valid", s_out_valid, 1);
         chk("small_data", s_out, (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3);
         @(posedge clk); #1;
      end
      s_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
